// File: rtl/sub_pkg.sv
// sub_pkg: shared types and limits for the bit-serial subtractor
package sub_pkg;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} sub_state_t;

    localparam int SUB_MAX_WIDTH = 64;

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit subtract cell, Diff = A - B - Bin with borrow out
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic Diff,
    output logic Borrow
);

    // borrow whenever A is too small to cover B plus the incoming borrow
    always_comb begin
        Diff   = A ^ B ^ Bin;
        Borrow = (~A & B) | (~(A ^ B) & Bin);
    end

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: WIDTH-bit subtractor that walks one bit per cycle through a single cell
module serial_subtractor_ctrl
    import sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    sub_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cell_diff, cell_borrow;
    logic             accept, shifting, last;

    full_subtractor u_cell (
        .A      (a_sh_q[0]),
        .B      (b_sh_q[0]),
        .Bin    (borrow_q),
        .Diff   (cell_diff),
        .Borrow (cell_borrow)
    );

    // all state advances on the rising edge; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            cnt_q    <= cnt_d;
        end
    end

    // next state: accept in IDLE, leave SHIFT after the last bit, leave DONE on consumer handshake
    always_comb begin
        accept   = (state_q == S_IDLE) && in_valid;
        shifting = (state_q == S_SHIFT);
        last     = shifting && (cnt_q == CNT_LAST);
        state_d  = accept                                ? S_SHIFT :
                   last                                  ? S_DONE  :
                   (state_q == S_DONE) && out_ready      ? S_IDLE  :
                   (state_q inside {S_SHIFT, S_DONE})    ? state_q : S_IDLE;
    end

    // datapath: load on accept, shift LSB-first while in SHIFT, capture the result on the last bit
    always_comb begin
        a_sh_d   = accept ? a   : shifting ? a_sh_q >> 1 : a_sh_q;
        b_sh_d   = accept ? b   : shifting ? b_sh_q >> 1 : b_sh_q;
        borrow_d = accept ? bin : shifting ? cell_borrow : borrow_q;
        res_d    = accept ? '0  : shifting ? {cell_diff, res_q[WIDTH-1:1]} : res_q;
        cnt_d    = accept ? '0  : (shifting && !last) ? cnt_q + CW'(1) : cnt_q;
        diff_d   = last ? res_d       : diff_q;
        bout_d   = last ? cell_borrow : bout_q;
    end

    // outputs: handshakes follow the state, results come from the held capture registers
    always_comb begin
        in_ready   = (state_q == S_IDLE);
        out_valid  = (state_q == S_DONE);
        diff       = diff_q;
        borrow_out = bout_q;
    end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb_serial_subtractor_ctrl: directed and random checks of the serial subtractor at widths 8, 2 and 16
module tb_serial_subtractor_ctrl;

    logic        clk;
    logic        rst;
    logic [2:0]  in_valid_v, in_ready_v, out_valid_v, out_ready_v, bin_v, borrow_v;
    logic [15:0] a_v [3];
    logic [15:0] b_v [3];
    logic [7:0]  diff8;
    logic [1:0]  diff2;
    logic [15:0] diff16;

    int          checks = 0;
    int          errors = 0;
    logic        chk_en = 0;
    logic        rnd_en = 0;
    logic [16:0] exp_q [3][$];
    logic [16:0] last_r [3];
    logic        busy [3];
    int          since [3];
    int          pops [3];
    logic        b0, ev;

    serial_subtractor_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_v[0][7:0]), .b(b_v[0][7:0]), .bin(bin_v[0]), .out_valid(out_valid_v[0]),
        .out_ready(out_ready_v[0]), .diff(diff8), .borrow_out(borrow_v[0])
    );

    serial_subtractor_ctrl #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_v[1][1:0]), .b(b_v[1][1:0]), .bin(bin_v[1]), .out_valid(out_valid_v[1]),
        .out_ready(out_ready_v[1]), .diff(diff2), .borrow_out(borrow_v[1])
    );

    serial_subtractor_ctrl #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a_v[2]), .b(b_v[2]), .bin(bin_v[2]), .out_valid(out_valid_v[2]),
        .out_ready(out_ready_v[2]), .diff(diff16), .borrow_out(borrow_v[2])
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic int wof(input int i);
        return (i == 0) ? 8 : (i == 1) ? 2 : 16;
    endfunction

    function automatic logic [15:0] get_diff(input int i);
        return (i == 0) ? {8'h0, diff8} : (i == 1) ? {14'h0, diff2} : diff16;
    endfunction

    // {borrow, diff} = a - b - bin, evaluated in wider arithmetic and split at bit WIDTH
    function automatic logic [16:0] model(input int i, input logic [15:0] a, input logic [15:0] b, input logic bi);
        logic [16:0] m, r;
        m = (17'd1 << wof(i)) - 17'd1;
        r = {1'b0, a & m[15:0]} - {1'b0, b & m[15:0]} - {16'h0, bi};
        return {r[wof(i)], r[15:0] & m[15:0]};
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d t=%0t actual=%h expected=%h", nm, i, $time, act, exp);
        end
    endtask

    // transaction-level model: one outstanding job per instance, result due WIDTH cycles after accept
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                b0 = busy[i];
                ev = b0 && (since[i] >= wof(i));
                chk("in_ready", i, {31'h0, in_ready_v[i]}, {31'h0, !b0});
                chk("out_valid", i, {31'h0, out_valid_v[i]}, {31'h0, ev});
                chk("result", i, {15'h0, borrow_v[i], get_diff(i)}, {15'h0, ev ? exp_q[i][0] : last_r[i]});
                if (ev && out_ready_v[i]) begin
                    last_r[i] = exp_q[i].pop_front();
                    busy[i] = 0;
                    pops[i]++;
                end else if (b0) since[i]++;
                if (!b0 && in_valid_v[i]) begin
                    exp_q[i].push_back(model(i, a_v[i], b_v[i], bin_v[i]));
                    busy[i] = 1;
                    since[i] = 0;
                end
            end
        end
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                exp_q[i].delete();
                busy[i] = 0;
                since[i] = 0;
                last_r[i] = '0;
            end
            chk_en = 1;
        end
    end

    // random consumer back-pressure during the soak phase
    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_en) for (int i = 0; i < 3; i++) out_ready_v[i] = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input int i, input logic [15:0] a, input logic [15:0] b, input logic bi);
        int n = 0;
        a_v[i] = a;
        b_v[i] = b;
        bin_v[i] = bi;
        in_valid_v[i] = 1;
        @(negedge clk);
        while (!in_ready_v[i] && n < 3000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 3000) chk("accept_timeout", i, n, 0);
        @(posedge clk);
        #1 in_valid_v[i] = 0;
    endtask

    task automatic lit(input logic [7:0] a, input logic [7:0] b, input logic bi, input logic [7:0] ed, input logic eb);
        int n = 0;
        send(0, {8'h0, a}, {8'h0, b}, bi);
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid_v[0] && n < 100);
        chk("latency", 0, n, 9);
        chk("diff_lit", 0, {24'h0, diff8}, {24'h0, ed});
        chk("borrow_lit", 0, {31'h0, borrow_v[0]}, {31'h0, eb});
        @(posedge clk);
        #1;
    endtask

    task automatic soak(input int i, input int cnt);
        for (int k = 0; k < cnt; k++)
            send(i, 16'($urandom), 16'($urandom), 1'($urandom));
    endtask

    initial begin
        int base [3];
        int n;
        rst = 1;
        in_valid_v = '0;
        out_ready_v = '1;
        bin_v = '0;
        for (int i = 0; i < 3; i++) begin
            a_v[i] = '0;
            b_v[i] = '0;
            pops[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_in_ready", 0, {31'h0, in_ready_v[0]}, 1);
        chk("rst_out_valid", 0, {31'h0, out_valid_v[0]}, 0);
        chk("rst_diff", 0, {24'h0, diff8}, 0);
        @(posedge clk);
        #1;
        lit(8'h5A, 8'h3C, 0, 8'h1E, 0);
        lit(8'h00, 8'h01, 0, 8'hFF, 1);
        lit(8'h80, 8'h7F, 1, 8'h00, 0);
        lit(8'hFF, 8'hFF, 1, 8'hFF, 1);
        out_ready_v[0] = 0;
        lit(8'hC3, 8'h5A, 0, 8'h69, 0);
        for (int k = 0; k < 5; k++) begin
            in_valid_v[0] = 1;
            a_v[0] = 16'(k * 37 + 5);
            b_v[0] = 16'(k * 11 + 90);
            @(negedge clk);
            chk("stall_in_ready", 0, {31'h0, in_ready_v[0]}, 0);
            chk("stall_out_valid", 0, {31'h0, out_valid_v[0]}, 1);
            chk("stall_diff", 0, {24'h0, diff8}, 32'h69);
            @(posedge clk);
            #1;
        end
        in_valid_v[0] = 0;
        out_ready_v[0] = 1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("drain_out_valid", 0, {31'h0, out_valid_v[0]}, 0);
        chk("drain_held_diff", 0, {24'h0, diff8}, 32'h69);
        @(posedge clk);
        #1;
        send(0, 16'h33, 16'h11, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("abort_in_ready", 0, {31'h0, in_ready_v[0]}, 1);
        chk("abort_out_valid", 0, {31'h0, out_valid_v[0]}, 0);
        chk("abort_diff", 0, {24'h0, diff8}, 0);
        @(posedge clk);
        #1;
        lit(8'h10, 8'h01, 0, 8'h0F, 0);
        for (int i = 0; i < 3; i++) base[i] = pops[i];
        rnd_en = 1;
        fork
            soak(0, 1000);
            soak(1, 1000);
            soak(2, 1000);
        join
        rnd_en = 0;
        @(posedge clk);
        #1 out_ready_v = '1;
        n = 0;
        while ((busy[0] || busy[1] || busy[2]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 3; i++) chk("soak_count", i, pops[i] - base[i], 1000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
